// File: rtl/t2mi_pace_ctrl_pkg.sv
// Shared encodings for the T2-MI pacing controller: packetizer monitor
// states, controller states and the credit ceiling.
package t2mi_pace_ctrl_pkg;

  localparam int unsigned CREDIT_MAX = 15;

  typedef enum logic [3:0] {
    PS_HEADER = 4'd0,
    PS_UP     = 4'd3,
    PS_CRC32  = 4'd7
  } pkt_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DRAIN
  } ctrl_state_e;

endpackage

// File: rtl/t2mi_rate_nco.sv
// Fractional-rate credit generator: phase accumulator whose carry-out
// mints one credit, held in a saturating counter.
module t2mi_rate_nco #(
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned CREDIT_MAX = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic [ACC_W-1:0] rate_inc,
  input  logic             consume,
  output logic             credit_avail
);

  localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    credits;
  logic [ACC_W:0]   sum;
  logic             carry;

  always_comb begin
    sum          = {1'b0, acc} + {1'b0, rate_inc};
    carry        = sum[ACC_W];
    credit_avail = (credits != '0) || carry;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc     <= '0;
      credits <= '0;
    end else if (clear) begin
      acc     <= '0;
      credits <= '0;
    end else begin
      acc <= sum[ACC_W-1:0];
      if (carry && !consume && (credits != CW'(CREDIT_MAX)))
        credits <= credits + 1'b1;
      else if (!carry && consume && (credits != '0))
        credits <= credits - 1'b1;
    end
  end

endmodule

// File: rtl/t2mi_pace_ctrl.sv
// Paces the T2-MI packetizer clock-enable from a credit NCO, gated by FIFO
// priming/backpressure, and stops only on packet boundaries.
module t2mi_pace_ctrl
  import t2mi_pace_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W         = 24,
  parameter int unsigned CREDIT_MAX    = t2mi_pace_ctrl_pkg::CREDIT_MAX,
  parameter int unsigned USEDW_W       = 11,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               run,
  input  logic [ACC_W-1:0]   rate_inc,
  input  logic [USEDW_W-1:0] prime_level,
  input  logic [USEDW_W-1:0] afull_level,
  input  logic [USEDW_W-1:0] ts_usedw,
  input  logic               ts_empty,
  input  logic [USEDW_W-1:0] out_usedw,
  input  logic [3:0]         pkt_state,
  output logic               ena_ts2t2mi,
  output logic               busy,
  output logic               underflow,
  output logic               drain_timeout,
  output logic [15:0]        stall_cnt
);

  localparam int unsigned DCNT_W = $clog2(DRAIN_TIMEOUT + 1);

  ctrl_state_e       state, state_next;
  logic [3:0]        prev_pkt_state;
  logic [DCNT_W-1:0] drain_cnt;
  logic              credit_avail, fire, boundary, stall;
  logic              restart, timeout_hit, drain_clr, drain_inc;

  // The credit is charged when the enable is issued, not when the registered
  // enable is seen, so one credit can never yield two enables.
  t2mi_rate_nco #(
    .ACC_W      (ACC_W),
    .CREDIT_MAX (CREDIT_MAX)
  ) u_nco (
    .CLK          (CLK),
    .RST          (RST),
    .clear        (state == ST_IDLE),
    .rate_inc     (rate_inc),
    .consume      (fire),
    .credit_avail (credit_avail)
  );

  always_comb begin
    boundary = (prev_pkt_state == PS_CRC32) && (pkt_state == PS_HEADER);
    fire     = ((state == ST_RUN) || (state == ST_DRAIN)) && credit_avail &&
               (out_usedw < afull_level);
    stall    = ena_ts2t2mi && (pkt_state == PS_UP) && ts_empty;
    busy     = (state != ST_IDLE);
  end

  always_comb begin
    state_next  = state;
    restart     = 1'b0;
    timeout_hit = 1'b0;
    drain_clr   = 1'b0;
    drain_inc   = 1'b0;
    case (state)
      ST_IDLE:
        if (run) begin
          state_next = ST_PRIME;
          restart    = 1'b1;
        end
      ST_PRIME:
        if (!run)                           state_next = ST_IDLE;
        else if (ts_usedw >= prime_level)   state_next = ST_RUN;
      ST_RUN:
        if (!run) begin
          state_next = ST_DRAIN;
          drain_clr  = 1'b1;
        end
      ST_DRAIN:
        if (run)           state_next = ST_RUN;
        else if (boundary) state_next = ST_IDLE;
        else if (drain_cnt == DCNT_W'(DRAIN_TIMEOUT)) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end else       drain_inc = 1'b1;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_pkt_state <= '0;
      drain_cnt      <= '0;
      ena_ts2t2mi    <= 1'b0;
      underflow      <= 1'b0;
      drain_timeout  <= 1'b0;
      stall_cnt      <= '0;
    end else begin
      prev_pkt_state <= pkt_state;
      ena_ts2t2mi    <= fire;
      if (drain_clr)      drain_cnt <= '0;
      else if (drain_inc) drain_cnt <= drain_cnt + 1'b1;
      if (restart) begin
        underflow     <= 1'b0;
        drain_timeout <= 1'b0;
        stall_cnt     <= '0;
      end else begin
        if (stall) begin
          underflow <= 1'b1;
          if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
        if (timeout_hit) drain_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_t2mi_pace_ctrl.sv
// Self-checking bench for t2mi_pace_ctrl: vector table, directed corner
// sequences and randomized stimulus against a behavioural model.
module tb_t2mi_pace_ctrl;

  localparam int unsigned TB_DT = 1000;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_DRAIN = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        run;
  logic [23:0] rate_inc;
  logic [10:0] prime_level, afull_level, ts_usedw, out_usedw;
  logic        ts_empty;
  logic [3:0]  pkt_state;
  logic        ena_ts2t2mi, busy, underflow, drain_timeout;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  t2mi_pace_ctrl #(
    .ACC_W         (24),
    .CREDIT_MAX    (15),
    .USEDW_W       (11),
    .DRAIN_TIMEOUT (TB_DT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .run           (run),
    .rate_inc      (rate_inc),
    .prime_level   (prime_level),
    .afull_level   (afull_level),
    .ts_usedw      (ts_usedw),
    .ts_empty      (ts_empty),
    .out_usedw     (out_usedw),
    .pkt_state     (pkt_state),
    .ena_ts2t2mi   (ena_ts2t2mi),
    .busy          (busy),
    .underflow     (underflow),
    .drain_timeout (drain_timeout),
    .stall_cnt     (stall_cnt)
  );

  // Behavioural model: plain integer bookkeeping of the controller rules.
  int    m_st, m_cred, m_prev, m_dcnt, m_stall;
  longint m_acc;
  bit    m_ena, m_und, m_dto;

  task automatic model_reset();
    m_st = M_IDLE; m_cred = 0; m_prev = 0; m_dcnt = 0; m_stall = 0;
    m_acc = 0; m_ena = 0; m_und = 0; m_dto = 0;
  endtask

  task automatic model_step();
    longint sum;
    bit active, carry, fire, stall, bnd, restart, tmo;
    int nst, nc;
    active  = (m_st != M_IDLE);
    sum     = m_acc + longint'(rate_inc);
    carry   = active && (sum >= 64'd16777216);
    fire    = (m_st == M_RUN || m_st == M_DRAIN) && (m_cred > 0 || carry) &&
              (int'(out_usedw) < int'(afull_level));
    stall   = m_ena && (pkt_state == 4'd3) && ts_empty;
    bnd     = (m_prev == 7) && (pkt_state == 4'd0);
    restart = 0; tmo = 0; nst = m_st;
    if (m_st == M_IDLE) begin
      if (run) begin nst = M_PRIME; restart = 1; end
    end else if (m_st == M_PRIME) begin
      if (!run) nst = M_IDLE;
      else if (int'(ts_usedw) >= int'(prime_level)) nst = M_RUN;
    end else if (m_st == M_RUN) begin
      if (!run) begin nst = M_DRAIN; m_dcnt = 0; end
    end else begin
      if (run) nst = M_RUN;
      else if (bnd) nst = M_IDLE;
      else if (m_dcnt == int'(TB_DT)) begin nst = M_IDLE; tmo = 1; end
      else m_dcnt = m_dcnt + 1;
    end
    nc = m_cred + int'(carry) - int'(fire);
    if (nc > 15) nc = 15;
    if (nc < 0) nc = 0;
    m_cred = active ? nc : 0;
    m_acc  = active ? (sum % 64'd16777216) : 0;
    if (restart) begin
      m_und = 0; m_dto = 0; m_stall = 0;
    end else begin
      if (stall) begin
        m_und = 1;
        if (m_stall < 65535) m_stall = m_stall + 1;
      end
      if (tmo) m_dto = 1;
    end
    m_ena  = fire;
    m_prev = int'(pkt_state);
    m_st   = nst;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_ena"},   32'(ena_ts2t2mi),   32'(m_ena));
    chk({tag, "_busy"},  32'(busy),          32'(m_st != M_IDLE));
    chk({tag, "_under"}, 32'(underflow),     32'(m_und));
    chk({tag, "_dto"},   32'(drain_timeout), 32'(m_dto));
    chk({tag, "_stall"}, 32'(stall_cnt),     32'(m_stall));
  endtask

  task automatic tick();
    if (RST) model_step();
    else     model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; run = 1'b0; rate_inc = '0; prime_level = '0; afull_level = '0;
    ts_usedw = '0; out_usedw = '0; ts_empty = 1'b0; pkt_state = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  typedef struct {
    logic        run;
    logic [10:0] ts_usedw;
    logic [10:0] out_usedw;
    logic [3:0]  pkt;
    logic        empty;
    logic        e_ena, e_busy, e_und, e_dto;
    logic [15:0] e_stall;
  } vec_t;

  function automatic vec_t mkv(input logic r, input int tsu, input int ou, input int pk,
                               input logic em, input logic ee, input logic eb,
                               input logic eu, input int es);
    vec_t v;
    v.run = r; v.ts_usedw = 11'(tsu); v.out_usedw = 11'(ou); v.pkt = 4'(pk);
    v.empty = em; v.e_ena = ee; v.e_busy = eb; v.e_und = eu; v.e_dto = 1'b0;
    v.e_stall = 16'(es);
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, pairs;
    logic prev;

    // rate_inc = all ones, prime_level 188, afull_level 1024 throughout
    //            run tsu  out   pkt em  ena busy und stall
    tbl[0]  = mkv(1, 100, 0,    0, 0,  0, 1, 0, 0);
    tbl[1]  = mkv(1, 100, 0,    0, 0,  0, 1, 0, 0);
    tbl[2]  = mkv(1, 100, 0,    0, 0,  0, 1, 0, 0);
    tbl[3]  = mkv(1, 188, 0,    0, 0,  0, 1, 0, 0);
    tbl[4]  = mkv(1, 188, 0,    0, 0,  1, 1, 0, 0);
    tbl[5]  = mkv(1, 188, 1024, 0, 0,  0, 1, 0, 0);
    tbl[6]  = mkv(1, 188, 1024, 0, 0,  0, 1, 0, 0);
    tbl[7]  = mkv(1, 188, 0,    0, 0,  1, 1, 0, 0);
    tbl[8]  = mkv(0, 188, 0,    3, 1,  1, 1, 1, 1);
    tbl[9]  = mkv(0, 188, 0,    7, 1,  1, 1, 1, 1);
    tbl[10] = mkv(0, 188, 0,    0, 0,  1, 0, 1, 1);
    tbl[11] = mkv(0, 188, 0,    0, 0,  0, 0, 1, 1);
    tbl[12] = mkv(1, 188, 0,    0, 0,  0, 1, 0, 0);

    do_reset();
    chk("reset_ena", 32'(ena_ts2t2mi), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_under", 32'(underflow), 0);
    chk("reset_dto", 32'(drain_timeout), 0);
    chk("reset_stall", 32'(stall_cnt), 0);

    // Vector table
    rate_inc = '1; prime_level = 11'd188; afull_level = 11'd1024;
    for (int i = 0; i < 13; i++) begin
      run = tbl[i].run; ts_usedw = tbl[i].ts_usedw; out_usedw = tbl[i].out_usedw;
      pkt_state = tbl[i].pkt; ts_empty = tbl[i].empty;
      tick();
      chk($sformatf("tbl%0d_ena", i),   32'(ena_ts2t2mi),   32'(tbl[i].e_ena));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),          32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_under", i), 32'(underflow),     32'(tbl[i].e_und));
      chk($sformatf("tbl%0d_dto", i),   32'(drain_timeout), 32'(tbl[i].e_dto));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt),     32'(tbl[i].e_stall));
    end

    // Pacing at 1/4 rate
    do_reset();
    rate_inc = 24'h400000; prime_level = 11'd188; ts_usedw = 11'd200;
    afull_level = 11'd1024; run = 1'b1;
    repeat (40) tick();
    n = 0; pairs = 0; prev = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (ena_ts2t2mi) n++;
      if (ena_ts2t2mi && prev) pairs++;
      prev = ena_ts2t2mi;
    end
    chk("pace_count", 32'(n), 250);
    chk("pace_consecutive", 32'(pairs), 0);

    // Backpressure and afull_level = 0
    do_reset();
    rate_inc = '1; prime_level = 11'd188; ts_usedw = 11'd200;
    afull_level = 11'd1024; run = 1'b1;
    repeat (10) tick();
    chk("bp_pre_ena", 32'(ena_ts2t2mi), 1);
    out_usedw = 11'd1024;
    tick();
    chk("bp_first_blocked", 32'(ena_ts2t2mi), 0);
    n = 0;
    repeat (25) begin tick(); n += int'(ena_ts2t2mi); end
    chk("bp_blocked_cnt", 32'(n), 0);
    out_usedw = 11'd0; n = 0;
    repeat (20) begin tick(); n += int'(ena_ts2t2mi); end
    chk("bp_release_cnt", 32'(n), 20);
    afull_level = 11'd0; n = 0;
    repeat (10) begin tick(); n += int'(ena_ts2t2mi); end
    chk("afull0_cnt", 32'(n), 0);

    // Drain with pkt_state frozen in user packets -> forced stop
    do_reset();
    rate_inc = '1; prime_level = 11'd188; ts_usedw = 11'd200;
    afull_level = 11'd1024; pkt_state = 4'd3; run = 1'b1;
    repeat (10) tick();
    run = 1'b0;
    tick();
    n = 0;
    while (busy && n < int'(TB_DT) + 10) begin
      n++;
      tick();
    end
    chk("drain_tmo_cycles", 32'(n), TB_DT + 1);
    chk("drain_tmo_flag", 32'(drain_timeout), 1);
    chk("drain_tmo_last_ena", 32'(ena_ts2t2mi), 1);
    tick();
    chk("drain_tmo_ena_drop", 32'(ena_ts2t2mi), 0);

    // Underflow: five stall cycles, then cleared by IDLE->PRIME
    do_reset();
    rate_inc = '1; prime_level = 11'd188; ts_usedw = 11'd200;
    afull_level = 11'd1024; pkt_state = 4'd3; run = 1'b1;
    repeat (10) tick();
    ts_empty = 1'b1;
    repeat (5) tick();
    ts_empty = 1'b0;
    tick();
    chk("uf_flag", 32'(underflow), 1);
    chk("uf_cnt", 32'(stall_cnt), 5);
    run = 1'b0; pkt_state = 4'd7;
    tick();
    pkt_state = 4'd0;
    tick();
    chk("uf_idle_busy", 32'(busy), 0);
    chk("uf_idle_dto", 32'(drain_timeout), 0);
    chk("uf_idle_cnt_held", 32'(stall_cnt), 5);
    run = 1'b1;
    tick();
    chk("uf_restart_flag", 32'(underflow), 0);
    chk("uf_restart_cnt", 32'(stall_cnt), 0);

    // Reset mid-RUN, then no stale credits with rate_inc = 0
    repeat (10) tick();
    ts_empty = 1'b1; pkt_state = 4'd3;
    repeat (3) tick();
    #3 RST = 1'b0;
    #1;
    chk("rst_async_ena", 32'(ena_ts2t2mi), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_stall", 32'(stall_cnt), 0);
    tick();
    chk("rst_edge_ena", 32'(ena_ts2t2mi), 0);
    chk("rst_edge_under", 32'(underflow), 0);
    RST = 1'b1; rate_inc = '0; ts_empty = 1'b0;
    n = 0;
    repeat (30) begin tick(); n += int'(ena_ts2t2mi); end
    chk("rst_no_credit_ena", 32'(n), 0);

    // Randomized stimulus against the model
    do_reset();
    run = 1'b1; rate_inc = 24'h555555; prime_level = 11'd50; afull_level = 11'd1024;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 199) == 0)
        case ($urandom_range(0, 3))
          0:       rate_inc = '0;
          1:       rate_inc = '1;
          2:       rate_inc = 24'h400000;
          default: rate_inc = 24'($urandom());
        endcase
      if ($urandom_range(0, 299) == 0)
        prime_level = ($urandom_range(0, 2) == 0) ? 11'd0 : 11'($urandom_range(1, 300));
      if ($urandom_range(0, 299) == 0)
        afull_level = ($urandom_range(0, 4) == 0) ? 11'd0 : 11'($urandom_range(100, 1024));
      ts_usedw  = 11'($urandom_range(0, 400));
      out_usedw = 11'($urandom_range(0, 1100));
      ts_empty  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       pkt_state = 4'd0;
        1:       pkt_state = 4'd3;
        2:       pkt_state = 4'd7;
        default: pkt_state = 4'($urandom_range(0, 15));
      endcase
      tick();
      chk_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
